// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and tree-PLRU helpers for icache_sa
// INVAL state exists only when ICACHE_CACOP_EN is defined.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    REFILL
`ifdef ICACHE_CACOP_EN
    , INVAL
`endif
  } state_t;

  localparam logic RD_TYPE_WORD = 1'b0;
  localparam logic RD_TYPE_LINE = 1'b1;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit 0 steers left.
  function automatic logic [2:0] plru_victim(input logic [6:0] tree, input int ways);
    logic [2:0] v;
    v = 3'd0;
    if (ways == 2) begin
      v = {2'b00, tree[0]};
    end else if (ways == 4) begin
      v = tree[0] ? {2'b01, tree[2]} : {2'b00, tree[1]};
    end else if (ways == 8) begin
      if (!tree[0]) v = tree[1] ? {2'b01, tree[4]} : {2'b00, tree[3]};
      else          v = tree[2] ? {2'b11, tree[6]} : {2'b10, tree[5]};
    end
    return v;
  endfunction

  function automatic logic [6:0] plru_update(input logic [6:0] tree, input logic [2:0] way,
                                             input int ways);
    logic [6:0] t;
    t = tree;
    if (ways == 2) begin
      t[0] = ~way[0];
    end else if (ways == 4) begin
      t[0] = ~way[1];
      if (way[1]) t[2] = ~way[0];
      else        t[1] = ~way[0];
    end else if (ways == 8) begin
      t[0] = ~way[2];
      if (!way[2]) begin
        t[1] = ~way[1];
        if (!way[1]) t[3] = ~way[0];
        else         t[4] = ~way[0];
      end else begin
        t[2] = ~way[1];
        if (!way[1]) t[5] = ~way[0];
        else         t[6] = ~way[0];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - fetch-side handshake and read-bridge signals of icache_sa
interface icache_sa_if #(
  parameter int LINE_WORDS = 4
);
  logic                      valid;
  logic                      uncache;
  logic [31:0]               addr;
  logic                      addr_ok;
  logic                      data_ok;
  logic [31:0]               rdata;
  logic                      rd_req;
  logic                      rd_type;
  logic [31:0]               rd_addr;
  logic                      rd_rdy;
  logic                      ret_valid;
  logic [32*LINE_WORDS-1:0]  ret_data;

  modport master (
    output valid, uncache, addr, rd_rdy, ret_valid, ret_data,
    input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );

  modport slave (
    input  valid, uncache, addr, rd_rdy, ret_valid, ret_data,
    output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );
endinterface

// File: rtl/icache_sram.sv
// rtl/icache_sram.sv - single-port synchronous-read RAM used for tag and data ways
module icache_sram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with tree-PLRU and uncached path
// Optional index invalidate port enabled by ICACHE_CACOP_EN.
module icache_sa
  import icache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 256,
  parameter int LINE_WORDS = 4,
  localparam int IDX = $clog2(SETS)
) (
  input  logic           clk,
  input  logic           reset,
  icache_sa_if.slave     bus
`ifdef ICACHE_CACOP_EN
  ,
  input  logic           cacop_valid,
  input  logic [IDX-1:0] cacop_index,
  output logic           cacop_ok
`endif
);
  localparam int OFF = $clog2(LINE_WORDS) + 2;
  localparam int WO  = OFF - 2;
  localparam int TAG = 32 - IDX - OFF;
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LW  = 32 * LINE_WORDS;
  localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;

  state_t state_q, state_n;
  logic             req_uncache_q;
  logic [TAG-1:0]   req_tag_q;
  logic [IDX-1:0]   req_idx_q;
  logic [WO-1:0]    req_off_q;
  logic [WB-1:0]    victim_q, victim_n, hit_way, plru_vic;
  logic [SETS-1:0]  valid_q [WAYS];
  logic [TAG-1:0]   tag_rd [WAYS];
  logic [LW-1:0]    line_rd [WAYS];
  logic [WAYS-1:0]  hit_vec;
  logic [LW-1:0]    hit_line;
  logic [IDX-1:0]   arr_addr;
  logic             hit, accept, refill_we, hit_upd;
  logic             data_ok, rd_req, rd_type;
  logic [31:0]      rdata, rd_addr;
  logic             unused_addr_bits;
`ifdef ICACHE_CACOP_EN
  logic             cacop_start;
  logic [IDX-1:0]   cacop_idx_q;
`endif

  assign unused_addr_bits = ^bus.addr[1:0];
  // Refill writes and acceptances are never in the same cycle, so one port suffices.
  assign arr_addr = refill_we ? req_idx_q : bus.addr[OFF +: IDX];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = refill_we && (victim_q == WB'(w));
    icache_sram #(.DEPTH(SETS), .WIDTH(TAG)) u_tag (
      .clk(clk), .en(accept), .we(way_we), .addr(arr_addr),
      .wdata(req_tag_q), .rdata(tag_rd[w]));
    icache_sram #(.DEPTH(SETS), .WIDTH(LW)) u_data (
      .clk(clk), .en(accept), .we(way_we), .addr(arr_addr),
      .wdata(bus.ret_data), .rdata(line_rd[w]));
    assign hit_vec[w] = valid_q[w][req_idx_q] && (tag_rd[w] == req_tag_q);
  end

  assign hit = (state_q == LOOKUP) && !req_uncache_q && (|hit_vec);

  always_comb begin
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) begin
        hit_way  = WB'(w);
        hit_line = line_rd[w];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins over the PLRU choice.
  always_comb begin
    victim_n = plru_vic;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx_q]) victim_n = WB'(w);
    end
  end

  if (WAYS > 1) begin : g_plru
    logic [PW-1:0] plru_q [SETS];
    logic [6:0]    plru_cur;
    assign plru_cur = 7'(plru_q[req_idx_q]);
    assign plru_vic = WB'(plru_victim(plru_cur, WAYS));
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (hit_upd) begin
        plru_q[req_idx_q] <= PW'(plru_update(plru_cur, 3'(hit_way), WAYS));
      end else if (refill_we) begin
        plru_q[req_idx_q] <= PW'(plru_update(plru_cur, 3'(victim_q), WAYS));
      end
    end
  end else begin : g_no_plru
    assign plru_vic = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (refill_we && (victim_q == WB'(w))) valid_q[w][req_idx_q] <= 1'b1;
`ifdef ICACHE_CACOP_EN
        if (state_q == INVAL) valid_q[w][cacop_idx_q] <= 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_uncache_q <= 1'b0;
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      req_off_q     <= '0;
      victim_q      <= '0;
`ifdef ICACHE_CACOP_EN
      cacop_idx_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      if (accept) begin
        req_uncache_q <= bus.uncache;
        req_tag_q     <= bus.addr[31 -: TAG];
        req_idx_q     <= bus.addr[OFF +: IDX];
        req_off_q     <= bus.addr[2 +: WO];
      end
      if ((state_q == LOOKUP) && !hit) victim_q <= victim_n;
`ifdef ICACHE_CACOP_EN
      if (cacop_start) cacop_idx_q <= cacop_index;
`endif
    end
  end

  always_comb begin
    state_n   = state_q;
    accept    = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    rd_req    = 1'b0;
    rd_type   = RD_TYPE_WORD;
    rd_addr   = '0;
    refill_we = 1'b0;
    hit_upd   = 1'b0;
`ifdef ICACHE_CACOP_EN
    cacop_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ICACHE_CACOP_EN
        if (cacop_valid) begin
          cacop_start = 1'b1;
          state_n     = INVAL;
        end else
`endif
        if (bus.valid) begin
          accept  = 1'b1;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          rdata   = hit_line[{req_off_q, 5'b0} +: 32];
          hit_upd = 1'b1;
          accept  = bus.valid;
          state_n = bus.valid ? LOOKUP : IDLE;
        end else begin
          state_n = MISS;
        end
      end
      MISS: begin
        rd_req  = 1'b1;
        rd_type = req_uncache_q ? RD_TYPE_WORD : RD_TYPE_LINE;
        rd_addr = req_uncache_q ? {req_tag_q, req_idx_q, req_off_q, 2'b00}
                                : {req_tag_q, req_idx_q, {OFF{1'b0}}};
        if (bus.rd_rdy) state_n = REFILL;
      end
      REFILL: begin
        if (bus.ret_valid) begin
          data_ok   = 1'b1;
          rdata     = req_uncache_q ? bus.ret_data[31:0]
                                    : bus.ret_data[{req_off_q, 5'b0} +: 32];
          refill_we = !req_uncache_q;
          state_n   = IDLE;
        end
      end
`ifdef ICACHE_CACOP_EN
      INVAL: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.addr_ok = accept;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = rdata;
  assign bus.rd_req  = rd_req;
  assign bus.rd_type = rd_type;
  assign bus.rd_addr = rd_addr;
`ifdef ICACHE_CACOP_EN
  assign cacop_ok = (state_q == INVAL);
`endif
endmodule
